ring_osc_meter: RTL and testbench

Multi-channel ring-oscillator bank with an on-chip frequency meter. It holds `CHANNELS` independently enabled ring oscillators of different lengths, each followed by a ripple divider. It counts rising edges of the selected channel's divided output over a programmable window of system-clock cycles. It is the successor to the single free-running oscillator: it adds channel count, enable gating and a clocked measurement path, for process/voltage characterisation from the host.

---
 rtl/ring_osc_meter.sv | 91 +++++++++
 tb/tb_ring_osc_meter.sv | 114 +++++++++++
 2 files changed

// File: rtl/ring_osc_meter.sv
// ring_osc_meter: gated ring-oscillator bank with ripple dividers and a clocked edge-count frequency meter
module ring_osc_meter #(
  parameter int CHANNELS = 4,
  parameter int CHAIN_LENGTH = 13,
  parameter int DIVIDER_BITS = 10,
  parameter int GATE_BITS = 16,
  parameter int COUNT_BITS = 16,
  parameter int STAGE_DELAY = 1,
  localparam int SEL_BITS = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SEL_BITS-1:0]   chan_sel,
  input  logic [GATE_BITS-1:0]  gate_cycles,
  output logic                  busy,
  output logic                  done,
  output logic [COUNT_BITS-1:0] count,
  output logic                  overflow
);
  localparam logic [1:0] IDLE = 2'd0, SETTLE = 2'd1, MEASURE = 2'd2, DONE = 2'd3;
  logic [1:0] state, state_n, settle;
  logic [SEL_BITS-1:0] sel_q, sel_n, sel_clamp;
  logic [GATE_BITS-1:0] gate_q, win;
  logic [COUNT_BITS-1:0] edge_cnt, cnt_n;
  logic ovf, ovf_n, prev, edge_det, sat;
  logic [1:0] sync;
  logic [CHANNELS-1:0] ring_en, div_msb;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    localparam int N = CHAIN_LENGTH + 2 * c;
    logic [N-1:0] s;
    logic clr;
    assign clr = ~ring_en[c];
    assign #(STAGE_DELAY) s[0] = ~(ring_en[c] & s[N-1]);
    for (genvar i = 1; i < N; i++) begin : g_inv
      assign #(STAGE_DELAY) s[i] = ~s[i-1];
    end
    for (genvar b = 0; b < DIVIDER_BITS; b++) begin : g_div
      logic q, ck;
      if (b == 0) begin : g_clk
        assign ck = s[N-1];
      end else begin : g_clk
        assign ck = ~g_div[b-1].q;
      end
      always_ff @(posedge ck or posedge clr) q <= clr ? 1'b0 : ~q;
    end
    assign div_msb[c] = g_div[DIVIDER_BITS-1].q;
  end
  always_comb begin
    sel_clamp = (32'(chan_sel) >= CHANNELS) ? SEL_BITS'(CHANNELS - 1) : chan_sel;
    sel_n = (state == IDLE && start) ? sel_clamp : sel_q;
    edge_det = sync[1] & ~prev;
    sat = &edge_cnt;
    cnt_n = state == SETTLE ? '0 : (state == MEASURE && edge_det && !sat) ? edge_cnt + 1'b1 : edge_cnt;
    ovf_n = state == SETTLE ? 1'b0 : ovf | (state == MEASURE && edge_det && sat);
    state_n = state == IDLE ? (start ? SETTLE : IDLE) :
              state == SETTLE ? (settle == 2'd3 ? (gate_q == '0 ? DONE : MEASURE) : SETTLE) :
              state == MEASURE ? (win == GATE_BITS'(1) ? DONE : MEASURE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      settle <= '0;
      sel_q <= '0;
      gate_q <= '0;
      win <= '0;
      edge_cnt <= '0;
      ovf <= 1'b0;
      sync <= '0;
      prev <= 1'b0;
      count <= '0;
      overflow <= 1'b0;
      ring_en <= '0;
    end else begin
      state <= state_n;
      sel_q <= sel_n;
      gate_q <= (state == IDLE && start) ? gate_cycles : gate_q;
      settle <= state == SETTLE ? settle + 2'd1 : 2'd0;
      win <= state == SETTLE ? gate_q : state == MEASURE ? win - 1'b1 : win;
      edge_cnt <= cnt_n;
      ovf <= ovf_n;
      sync <= {sync[0], div_msb[sel_q]};
      prev <= sync[1];
      count <= (state_n == DONE && state != DONE) ? cnt_n : count;
      overflow <= (state_n == DONE && state != DONE) ? ovf_n : overflow;
      ring_en <= (state_n == SETTLE || state_n == MEASURE) ? CHANNELS'(1) << sel_n : '0;
    end
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: tb/tb_ring_osc_meter.sv
// tb_ring_osc_meter: scoreboard bench for ring_osc_meter with 1-unit inverter delay and 10-unit clock
module tb_ring_osc_meter;
  logic clk = 1'b0, rst = 1'b1, start_a = 1'b0, start_b = 1'b0;
  logic [1:0] chan_sel = '0;
  logic [15:0] gate_cycles = '0;
  logic busy_a, done_a, overflow_a, busy_b, done_b, overflow_b;
  logic [15:0] count_a;
  logic [3:0] count_b;
  int checks = 0, errors = 0, cyc = 0, dones_a = 0, dones_b = 0;
  typedef struct {int lo; int hi; int ovf; int lat; int c0;} exp_t;
  exp_t q_a[$], q_b[$];
  ring_osc_meter #(.DIVIDER_BITS(4), .STAGE_DELAY(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .chan_sel(chan_sel), .gate_cycles(gate_cycles),
    .busy(busy_a), .done(done_a), .count(count_a), .overflow(overflow_a)
  );
  ring_osc_meter #(.DIVIDER_BITS(4), .COUNT_BITS(4), .STAGE_DELAY(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .chan_sel(chan_sel), .gate_cycles(gate_cycles),
    .busy(busy_b), .done(done_b), .count(count_b), .overflow(overflow_b)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic score(input string tag, input exp_t e, input int cnt, input int ovf);
    chk($sformatf("%s_count_%0d_in_%0d..%0d", tag, cnt, e.lo, e.hi), int'(cnt >= e.lo && cnt <= e.hi), 1);
    chk({tag, "_overflow"}, ovf, e.ovf);
    chk({tag, "_latency"}, cyc - e.c0, e.lat);
  endtask
  always @(negedge clk) begin
    if (done_a) begin
      dones_a++;
      chk("a_unexpected_done", int'(q_a.size() > 0), 1);
      if (q_a.size() > 0) score("a", q_a.pop_front(), int'(count_a), int'(overflow_a));
    end
    if (done_b) begin
      dones_b++;
      chk("b_unexpected_done", int'(q_b.size() > 0), 1);
      if (q_b.size() > 0) score("b", q_b.pop_front(), int'(count_b), int'(overflow_b));
    end
  end
  task automatic launch(input bit b, input int sel, input int g, input int lo, input int hi, input int ovf, input bit expect_done);
    @(negedge clk);
    chan_sel = 2'(sel);
    gate_cycles = 16'(g);
    if (b) start_b = 1'b1;
    else start_a = 1'b1;
    if (expect_done && b) q_b.push_back('{lo, hi, ovf, g + 5, cyc});
    if (expect_done && !b) q_a.push_back('{lo, hi, ovf, g + 5, cyc});
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask
  task automatic wait_done(input bit b, input int bound);
    bit seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge clk);
      seen = b ? done_b : done_a;
    end
    chk(b ? "b_done_timeout" : "a_done_timeout", int'(seen), 1);
    @(negedge clk);
    chk(b ? "b_busy_after_done" : "a_busy_after_done", int'(b ? busy_b : busy_a), 0);
    chk(b ? "b_done_one_cycle" : "a_done_one_cycle", int'(b ? done_b : done_a), 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_count", int'(count_a), 0);
    chk("rst_overflow", int'(overflow_a), 0);
    chk("rst_b_count", int'(count_b), 0);
    chk("rst_b_overflow", int'(overflow_b), 0);
    rst = 1'b0;
    launch(1'b0, 0, 1000, 23, 25, 0, 1'b1);
    chk("busy_after_start", int'(busy_a), 1);
    wait_done(1'b0, 1100);
    launch(1'b0, 1, 1000, 20, 22, 0, 1'b1);
    wait_done(1'b0, 1100);
    launch(1'b0, 7, 1000, 15, 17, 0, 1'b1);
    wait_done(1'b0, 1100);
    launch(1'b0, 0, 0, 0, 0, 0, 1'b1);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(1'b0, 20);
    repeat (20) @(negedge clk);
    chk("single_done_for_double_start", dones_a, 4);
    launch(1'b1, 0, 1000, 15, 15, 1, 1'b1);
    wait_done(1'b1, 1100);
    launch(1'b1, 0, 100, 1, 3, 0, 1'b1);
    wait_done(1'b1, 200);
    launch(1'b0, 0, 1000, 0, 0, 0, 1'b0);
    repeat (498) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(busy_a), 0);
    chk("abort_done", int'(done_a), 0);
    chk("abort_count", int'(count_a), 0);
    rst = 1'b0;
    repeat (1100) @(negedge clk);
    chk("abort_no_done", dones_a, 4);
    launch(1'b0, 0, 1000, 23, 25, 0, 1'b1);
    wait_done(1'b0, 1100);
    chk("total_dones_a", dones_a, 5);
    chk("total_dones_b", dones_b, 2);
    chk("scoreboard_drained", q_a.size() + q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
